exp_engine: RTL and testbench
=============================

EXP_ENGINE -- requirements
Module: exp_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning base operand width.
REQ-002 SHALL have parameter EXP_W, default 8, meaning exponent operand width.
REQ-003 SHALL have parameter RES_W, default 16, meaning result width; RES_W >= DATA_W.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port a_i  input  DATA_W  base, captured on accepted start.
REQ-008 SHALL have port n_i  input  EXP_W  exponent, captured on accepted start.
REQ-009 SHALL have port busy_o  output  1  high in RUN.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; result_o valid from this cycle.
REQ-011 SHALL have port result_o  output  RES_W  a_i^n_i, held until next done_o.
REQ-012 SHALL have port ovf_o  output  1  overflow flag, updated with result_o.

Function
REQ-013 SHALL implement FSM states IDLE and RUN only.
REQ-014 SHALL accept start in IDLE on edge 0: a_reg <= zero-extended a_i, n_reg <= n_i, res_reg <= 1, go to RUN.
REQ-015 SHALL, on each RUN edge with n_reg != 0: res_reg <= res_reg*a_reg if n_reg[0], else hold; a_reg <= a_reg*a_reg; n_reg <= n_reg >> 1.
REQ-016 SHALL, on the RUN edge with n_reg == 0: result_o <= res_reg, done_o <= 1, return to IDLE.
REQ-017 SHALL give latency: L = bit length of n_i (L=0 for n_i=0); done_o high in cycle after edge L+1; maximum EXP_W+1.
REQ-018 SHALL truncate all products to RES_W bits (modulo 2^RES_W) when EXP_SAT_EN is undefined.
REQ-019 SHALL define 0^0 = 1 and x^0 = 1.
REQ-020 SHALL ignore start_i while in RUN; it has no queueing and no effect on the result.
REQ-021 SHALL allow start_i in the done_o cycle (state already IDLE) to be accepted.
REQ-022 SHALL keep result_o and ovf_o unchanged except on done_o.

Reset
REQ-023 SHALL on rst low immediately force IDLE; busy_o=0, done_o=0, result_o=0, ovf_o=0, a_reg=n_reg=res_reg=0.
REQ-024 SHALL abort an operation in progress on reset with no done_o; the first start after release proceeds normally.

Configuration
REQ-025 SHALL, with EXP_SAT_EN defined, keep sticky a_ovf (set when a_reg*a_reg exceeds RES_W bits) and r_ovf (set when used product res_reg*a_reg exceeds RES_W bits or multiplies with a_ovf set); both clear on start.
REQ-026 SHALL, with EXP_SAT_EN defined, on done_o output result_o = all ones and ovf_o = 1 if r_ovf is set, else the exact result and ovf_o = 0.
REQ-027 SHALL, without EXP_SAT_EN, tie ovf_o to 0, omit overflow logic and wrap per REQ-018.

Structure
REQ-028 SHALL place the state enum and default width constants in shared package exp_pkg.
REQ-029 SHALL use one sub-module exp_mul (RES_W x RES_W -> RES_W truncated product plus overflow bit), instantiated twice (square, accumulate).

Verification
REQ-030 SHALL test a=3, n=5 -> done_o after edge 4 (L=3), result_o=243, ovf_o=0.
REQ-031 SHALL test a=7, n=0 and a=0, n=0 -> done_o after edge 1, result_o=1.
REQ-032 SHALL test a=255, n=2 -> result_o=65025, ovf_o=0; a=2, n=16 -> result_o=0 without macro, 0xFFFF with ovf_o=1 with EXP_SAT_EN.
REQ-033 SHALL test a=2, n=3 then start a=5, n=1 mid-run -> result_o=8 only; a later start computes 5.
REQ-034 SHALL test rst low mid-run for a=3, n=200 -> outputs 0 at once, no done_o; then a=2, n=4 -> result_o=16.
REQ-035 SHALL test back-to-back start asserted in the done_o cycle -> second operation accepted with no idle gap.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared definitions for the exponentiation engine: FSM state encoding and
// default operand/result widths.
package exp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_RES_W  = 16;

endpackage

// File: rtl/exp_mul.sv
// RES_W x RES_W multiplier returning the product truncated to RES_W bits.
// Optional macro EXP_SAT_EN adds an overflow bit that flags any non-zero
// bits above RES_W in the full product.
module exp_mul #(
  parameter int RES_W = 16
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
`ifdef EXP_SAT_EN
  output logic             ovf,
`endif
  output logic [RES_W-1:0] p
);

`ifdef EXP_SAT_EN
  logic [2*RES_W-1:0] full;

  assign full = {{RES_W{1'b0}}, a} * {{RES_W{1'b0}}, b};
  assign p    = full[RES_W-1:0];
  assign ovf  = |full[2*RES_W-1:RES_W];
`else
  // Wrap-around arithmetic: the product is taken modulo 2^RES_W.
  assign p = a * b;
`endif

endmodule

// File: rtl/exp_engine.sv
// Integer exponentiation a^n by square-and-multiply, one exponent bit per
// clock. Two-state FSM (IDLE/RUN); result_o/ovf_o only change on done_o.
// Optional macro EXP_SAT_EN: saturate to all ones and raise ovf_o when the
// exact result does not fit in RES_W bits; otherwise results wrap.
module exp_engine
  import exp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int RES_W  = DEF_RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [EXP_W-1:0]  n_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [RES_W-1:0]  result_o,
  output logic              ovf_o
);

  state_t           state;
  logic [RES_W-1:0] a_reg;
  logic [EXP_W-1:0] n_reg;
  logic [RES_W-1:0] res_reg;
  logic [RES_W-1:0] sq_p;
  logic [RES_W-1:0] acc_p;

`ifdef EXP_SAT_EN
  logic sq_ovf;
  logic acc_ovf;
  logic a_ovf;
  logic r_ovf;
`endif

  // Squaring path: a_reg -> a_reg^2
  exp_mul #(.RES_W(RES_W)) u_sq (
    .a   (a_reg),
    .b   (a_reg),
`ifdef EXP_SAT_EN
    .ovf (sq_ovf),
`endif
    .p   (sq_p)
  );

  // Accumulate path: res_reg -> res_reg * a_reg
  exp_mul #(.RES_W(RES_W)) u_acc (
    .a   (res_reg),
    .b   (a_reg),
`ifdef EXP_SAT_EN
    .ovf (acc_ovf),
`endif
    .p   (acc_p)
  );

`ifndef EXP_SAT_EN
  assign ovf_o = 1'b0;
`endif

  // Control FSM and datapath: accept in IDLE, one exponent bit per RUN edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      a_reg    <= '0;
      n_reg    <= '0;
      res_reg  <= '0;
`ifdef EXP_SAT_EN
      ovf_o    <= 1'b0;
      a_ovf    <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_reg   <= RES_W'(a_i);
            n_reg   <= n_i;
            res_reg <= RES_W'(1);
            busy_o  <= 1'b1;
            state   <= RUN;
`ifdef EXP_SAT_EN
            a_ovf   <= 1'b0;
            r_ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (n_reg != '0) begin
            if (n_reg[0]) begin
              res_reg <= acc_p;
`ifdef EXP_SAT_EN
              // A multiply by an already-wrapped base poisons the result too
              r_ovf   <= r_ovf | acc_ovf | a_ovf;
`endif
            end
            a_reg <= sq_p;
            n_reg <= n_reg >> 1;
`ifdef EXP_SAT_EN
            a_ovf <= a_ovf | sq_ovf;
`endif
          end else begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
`ifdef EXP_SAT_EN
            if (r_ovf) begin
              result_o <= '1;
              ovf_o    <= 1'b1;
            end else begin
              result_o <= res_reg;
              ovf_o    <= 1'b0;
            end
`else
            result_o <= res_reg;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_engine.sv
// Self-checking bench for exp_engine (default widths 8/8/16). Expected
// results are computed by a repeated-multiplication model and queued at
// issue time; the monitor pops them on done_o and also checks latency and
// that result_o/ovf_o hold between completions.
module tb_exp_engine;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  a_i;
  logic [7:0]  n_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] result_o;
  logic        ovf_o;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] last_res = '0;
  logic        last_ovf = 1'b0;

  exp_engine #(.DATA_W(8), .EXP_W(8), .RES_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .a_i      (a_i),
    .n_i      (n_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .ovf_o    (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp_v, exp_v, cyc);
    end
  endtask

  function automatic int bitlen(input logic [7:0] n);
    int l = 0;
    for (int i = 0; i < 8; i++) if (n[i]) l = i + 1;
    return l;
  endfunction

  // Reference: multiply a into an accumulator n times, tracking the exact
  // magnitude separately from the wrapped 16-bit value.
  task automatic model(input logic [7:0] a, input logic [7:0] n,
                       output logic [15:0] res, output logic ovf);
    logic [63:0] exact = 64'd1;
    logic [15:0] wrap  = 16'd1;
    logic        big   = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      wrap = wrap * 16'(a);
      if (!big) begin
        exact = exact * 64'(a);
        if (exact > 64'hFFFF) big = 1'b1;
      end
    end
`ifdef EXP_SAT_EN
    res = big ? 16'hFFFF : wrap;
    ovf = big;
`else
    res = wrap;
    ovf = 1'b0;
`endif
  endtask

  // Call at a negedge with the engine idle (or in its done cycle).
  task automatic issue(input logic [7:0] a, input logic [7:0] n);
    exp_t e;
    model(a, n, e.res, e.ovf);
    e.cyc = cyc + bitlen(n) + 2;
    sb_q.push_back(e);
    a_i     = a;
    n_i     = n;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done_o) return;
      @(negedge clk);
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] n);
    @(negedge clk);
    issue(a, n);
    wait_done();
  endtask

  // Monitor: score completions, and check outputs hold otherwise
  always @(negedge clk) begin
    if (rst) begin
      if (done_o) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", 32'(result_o), 32'(e.res));
          chk("ovf", 32'(ovf_o), 32'(e.ovf));
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          last_res = e.res;
          last_ovf = e.ovf;
        end
      end else begin
        chk("hold_result", 32'(result_o), 32'(last_res));
        chk("hold_ovf", 32'(ovf_o), 32'(last_ovf));
      end
    end
  end

  initial begin
    rst     = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    n_i     = '0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic, x^0 and 0^0, wide results
    run(8'd3, 8'd5);
    run(8'd7, 8'd0);
    run(8'd0, 8'd0);
    run(8'd255, 8'd2);
    run(8'd2, 8'd16);
    run(8'd1, 8'd200);
    run(8'd0, 8'd7);

    // start_i during RUN is ignored
    @(negedge clk);
    issue(8'd2, 8'd3);
    a_i     = 8'd5;
    n_i     = 8'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    run(8'd5, 8'd1);

    // Reset mid-run aborts with no done_o
    @(negedge clk);
    issue(8'd3, 8'd200);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    sb_q.delete();
    last_res = '0;
    last_ovf = 1'b0;
    #1;
    chk("abort_result", 32'(result_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    run(8'd2, 8'd4);

    // Back-to-back: next start issued in the done_o cycle
    run(8'd3, 8'd4);
    issue(8'd2, 8'd10);
    wait_done();
    issue(8'd10, 8'd3);
    wait_done();

    // A few random operands
    for (int k = 0; k < 6; k++) begin
      run(8'($urandom_range(0, 15)), 8'($urandom_range(0, 20)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
